// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, immediate formats and the fetch FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD
  } instr_fmt_t;

  typedef enum logic {
    IDLE, REQ
  } fetch_state_t;

  function automatic instr_fmt_t opcode_fmt(input logic [6:0] op);
    instr_fmt_t f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_SB;
      OP_LUI:                              f = FMT_U;
      OP_JAL:                              f = FMT_UJ;
      OP_R:                                f = FMT_R;
      default:                             f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies an instruction word and
// produces its sign-extended 64-bit immediate.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [63:0] imm,
  output instr_fmt_t  fmt,
  output logic        illegal
);

  always_comb begin
    fmt     = opcode_fmt(instr[6:0]);
    imm     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_SB:  imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_UJ:  imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_R:   imm = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches one word per fetch_req over
// a ready/valid memory handshake and exposes decoded IR fields.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic [63:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_instr,
  output logic [31:0] instr,
  output logic [6:0]  op_code,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [63:0] imm,
  output logic        instr_valid,
  output logic        busy,
  output logic        illegal,
  output logic        misalign
);

  fetch_state_t state_reg,       state_next;
  logic [63:0]  pc_val_reg,      pc_val_next;
  logic [63:0]  pc_instr_reg,    pc_instr_next;
  logic [31:0]  ir_reg,          ir_next;
  logic         pend_valid_reg,  pend_valid_next;
  logic [63:0]  pend_pc_reg,     pend_pc_next;
  logic         instr_valid_reg, instr_valid_next;
  logic         misalign_reg,    misalign_next;

  logic         load_ok;
  instr_fmt_t   ir_fmt;
  logic         gen_illegal;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE;
      pc_val_reg      <= PC_RESET;
      pc_instr_reg    <= '0;
      ir_reg          <= '0;
      pend_valid_reg  <= 1'b0;
      pend_pc_reg     <= '0;
      instr_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_val_reg      <= pc_val_next;
      pc_instr_reg    <= pc_instr_next;
      ir_reg          <= ir_next;
      pend_valid_reg  <= pend_valid_next;
      pend_pc_reg     <= pend_pc_next;
      instr_valid_reg <= instr_valid_next;
      misalign_reg    <= misalign_next;
    end
  end

  // Misaligned targets never reach the PC; they only raise the sticky flag.
  assign load_ok = pc_load && (pc_next[1:0] == 2'b00);

  always_comb begin
    state_next       = state_reg;
    pc_val_next      = pc_val_reg;
    pc_instr_next    = pc_instr_reg;
    ir_next          = ir_reg;
    pend_valid_next  = pend_valid_reg;
    pend_pc_next     = pend_pc_reg;
    instr_valid_next = instr_valid_reg;
    misalign_next    = misalign_reg | (pc_load & ~load_ok);

    case (state_reg)
      IDLE: begin
        if (load_ok) pc_val_next = pc_next;
        if (fetch_req) begin
          state_next       = REQ;
          instr_valid_next = 1'b0;
          pend_valid_next  = 1'b0;
        end
      end
      REQ: begin
        // imem_addr must stay stable while the request is outstanding.
        if (load_ok) begin
          pend_valid_next = 1'b1;
          pend_pc_next    = pc_next;
        end
        if (imem_valid) begin
          ir_next          = imem_rdata;
          pc_instr_next    = pc_val_reg;
          if (load_ok)             pc_val_next = pc_next;
          else if (pend_valid_reg) pc_val_next = pend_pc_reg;
          else                     pc_val_next = pc_val_reg + 64'd4;
          pend_valid_next  = 1'b0;
          instr_valid_next = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  imm_gen u_imm_gen (
    .instr   (ir_reg),
    .imm     (imm),
    .fmt     (ir_fmt),
    .illegal (gen_illegal)
  );

  assign imem_rd     = (state_reg == REQ);
  assign busy        = (state_reg == REQ);
  assign imem_addr   = pc_val_reg;
  assign pc          = pc_val_reg;
  assign pc_instr    = pc_instr_reg;
  assign instr       = ir_reg;
  assign instr_valid = instr_valid_reg;
  assign misalign    = misalign_reg;
  assign illegal     = gen_illegal | (ir_fmt == FMT_BAD);

  assign op_code = ir_reg[6:0];
  assign rd      = ir_reg[11:7];
  assign funct3  = ir_reg[14:12];
  assign rs1     = ir_reg[19:15];
  assign rs2     = ir_reg[24:20];
  assign funct7  = ir_reg[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_instr_fetch_unit;

  localparam logic [63:0] PCR = 64'h100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_req, pc_load, imem_valid;
  logic [63:0] pc_next;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr, pc, pc_instr, imm;
  logic        imem_rd, instr_valid, busy, illegal, misalign;
  logic [31:0] instr;
  logic [6:0]  op_code, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.PC_RESET(PCR)) dut (
    .CLK(CLK), .RST(RST), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_next(pc_next), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc),
    .pc_instr(pc_instr), .instr(instr), .op_code(op_code), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .instr_valid(instr_valid), .busy(busy), .illegal(illegal),
    .misalign(misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Immediate from arithmetic weights of the scattered fields, then two's-complement wrap.
  function automatic logic [63:0] model_imm(input logic [31:0] w);
    longint v = 0;
    int bits = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin v = longint'(w[31:20]); bits = 12; end
      7'h23: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); bits = 12; end
      7'h63: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        bits = 13;
      end
      7'h37: begin v = longint'(w[31:12]) * 4096; bits = 32; end
      7'h6F: begin
        v = longint'(w[31]) * (longint'(1) << 20) + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        bits = 21;
      end
      default: v = 0;
    endcase
    if (bits != 0 && w[31]) v = v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic model_illegal(input logic [31:0] w);
    return !(w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F});
  endfunction

  // Behavioural model: fetch in flight or not, plus PC / IR bookkeeping.
  logic        m_busy, m_valid, m_mis, m_pend_v;
  logic [63:0] m_pc, m_pc_instr, m_pend;
  logic [31:0] m_ir;
  logic        m_ok;

  always_comb m_ok = pc_load && (pc_next[1:0] == 2'b00);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_mis <= 1'b0; m_pend_v <= 1'b0;
      m_pc <= PCR; m_pc_instr <= '0; m_pend <= '0; m_ir <= '0;
    end else begin
      if (pc_load && !m_ok) m_mis <= 1'b1;
      if (!m_busy) begin
        if (m_ok) m_pc <= pc_next;
        if (fetch_req) begin m_busy <= 1'b1; m_valid <= 1'b0; end
      end else if (imem_valid) begin
        m_ir       <= imem_rdata;
        m_pc_instr <= m_pc;
        m_pc       <= m_ok ? pc_next : (m_pend_v ? m_pend : m_pc + 64'd4);
        m_pend_v   <= 1'b0;
        m_valid    <= 1'b1;
        m_busy     <= 1'b0;
      end else if (m_ok) begin
        m_pend_v <= 1'b1;
        m_pend   <= pc_next;
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_imem_rd", 64'(imem_rd), 64'(m_busy));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_pc_instr", pc_instr, m_pc_instr);
      chk("m_instr", 64'(instr), 64'(m_ir));
      chk("m_fields", {op_code, rd, funct3, rs1, rs2, funct7}, {m_ir[6:0], m_ir[11:7], m_ir[14:12], m_ir[19:15], m_ir[24:20], m_ir[31:25]});
      chk("m_imm", imm, model_imm(m_ir));
      chk("m_illegal", 64'(illegal), 64'(model_illegal(m_ir)));
      chk("m_instr_valid", 64'(instr_valid), 64'(m_valid));
      chk("m_misalign", 64'(misalign), 64'(m_mis));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (waits) tick();
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  int rd_cycles, busy_cycles;

  initial begin
    RST = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_next = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_pc", pc, 64'h100);
    chk("rst_pc_instr", pc_instr, 64'h0);
    chk("rst_flags", {instr_valid, busy, imem_rd, misalign, illegal}, 5'b00001);

    // Minimum-latency fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("first_rd", 64'(imem_rd), 64'd1);
    imem_valid = 1'b1; imem_rdata = 32'h00A00093;
    tick();
    imem_valid = 1'b0;
    chk("addi_instr", 64'(instr), 64'h00A00093);
    chk("addi_imm", imm, 64'd10);
    chk("addi_rd", 64'(rd), 64'd1);
    chk("addi_pc_instr", pc_instr, 64'h100);
    chk("addi_pc", pc, 64'h104);
    chk("addi_valid", 64'(instr_valid), 64'd1);

    // Three wait cycles, fetch_req pulsed mid-wait
    fetch_req = 1'b1;
    tick();
    rd_cycles = 0; busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_rd) rd_cycles++;
      if (busy) busy_cycles++;
      fetch_req  = (i == 1);
      imem_valid = (i == 3);
      imem_rdata = 32'h00500113;
      tick();
    end
    fetch_req = 1'b0; imem_valid = 1'b0;
    chk("wait_rd_cycles", 64'(rd_cycles), 64'd4);
    chk("wait_busy_cycles", 64'(busy_cycles), 64'd4);
    chk("wait_pc", pc, 64'h108);
    tick();
    chk("wait_no_queue", 64'(busy), 64'd0);
    chk("wait_pc_once", pc, 64'h108);

    do_fetch(32'hFE000EE3, 1);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_pc", pc, 64'h10C);
    do_fetch(32'h8000006F, 0);
    chk("jal_imm", imm, 64'hFFFF_FFFF_FFF0_0000);
    chk("jal_pc", pc, 64'h110);

    // Load during REQ is deferred to capture
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; pc_load = 1'b1; pc_next = 64'h200;
    tick();
    pc_load = 1'b0;
    chk("pend_addr_hold", imem_addr, 64'h110);
    tick();
    chk("pend_addr_hold2", imem_addr, 64'h110);
    imem_valid = 1'b1; imem_rdata = 32'h00000033;
    tick();
    imem_valid = 1'b0;
    chk("pend_pc", pc, 64'h200);
    chk("pend_pc_instr", pc_instr, 64'h110);
    chk("r_illegal", 64'(illegal), 64'd0);

    // Load together with fetch_req in IDLE
    pc_load = 1'b1; pc_next = 64'h300; fetch_req = 1'b1;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    chk("load_fetch_addr", imem_addr, 64'h300);
    chk("load_fetch_rd", 64'(imem_rd), 64'd1);
    imem_valid = 1'b1; imem_rdata = 32'h0000007F;
    tick();
    imem_valid = 1'b0;
    chk("bad_illegal", 64'(illegal), 64'd1);
    chk("bad_imm", imm, 64'd0);
    chk("bad_pc", pc, 64'h304);

    // Misaligned load
    pc_load = 1'b1; pc_next = 64'h202;
    tick();
    pc_load = 1'b0;
    chk("mis_pc", pc, 64'h304);
    chk("mis_flag", 64'(misalign), 64'd1);

    // PC wrap
    pc_load = 1'b1; pc_next = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_load = 1'b0;
    do_fetch(32'h00000013, 0);
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_pc_instr", pc_instr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset mid-fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("abort_rd_before", 64'(imem_rd), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_rd_async", 64'(imem_rd), 64'd0);
    chk("abort_pc", pc, 64'h100);
    chk("abort_misalign", 64'(misalign), 64'd0);
    imem_valid = 1'b1; imem_rdata = 32'h00A00093;
    tick();
    RST = 1'b0;
    tick();
    imem_valid = 1'b0;
    chk("late_valid_ignored", 64'(instr_valid), 64'd0);
    chk("late_instr", 64'(instr), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      fetch_req  = ($urandom_range(0, 2) == 0);
      pc_load    = ($urandom_range(0, 5) == 0);
      pc_next    = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) pc_next[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) pc_next[63:8] = '1;
      imem_valid = ($urandom_range(0, 2) == 0);
      imem_rdata = rand_instr();
      RST        = ($urandom_range(0, 399) == 0);
      tick();
    end
    RST = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; imem_valid = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the multicycle RISC-V core. It owns the program counter and the instruction register, and fetches one 32-bit instruction per `fetch_req` through a ready/valid handshake with instruction memory. It presents decoded fields and a sign-extended 64-bit immediate to the main control state machine. Branch and jump targets computed downstream are written back through `pc_load`.

## Interface
- `PC_RESET`, default 64'h0: PC value after reset; must be 4-byte aligned.
- `CLK  in  1`: clock, rising edge.
- `RST  in  1`: reset, asynchronous, active-high.
- `fetch_req  in  1`: single-cycle request from the control FSM to fetch the instruction at the current PC.
- `pc_load  in  1`: write `pc_next` into the PC (taken branch or jump).
- `pc_next  in  64`: new PC value.
- `imem_addr  out  64`: instruction memory address; equals the PC register.
- `imem_rd  out  1`: read request, held high until `imem_valid`.
- `imem_rdata  in  32`: instruction word; valid when `imem_valid`=1.
- `imem_valid  in  1`: memory response strobe.
- `pc  out  64`: current PC.
- `pc_instr  out  64`: address of the instruction held in the IR.
- `instr  out  32`: instruction register.
- `op_code  out  7`, `rd  out  5`, `funct3  out  3`, `rs1  out  5`, `rs2  out  5`, `funct7  out  7`: IR field slices.
- `imm  out  64`: sign-extended immediate of the IR.
- `instr_valid  out  1`: IR holds a fetched instruction.
- `busy  out  1`: fetch in progress.
- `illegal  out  1`: IR opcode is not in the supported set.
- `misalign  out  1`: sticky flag, set by a `pc_load` with `pc_next[1:0]`≠0.

## Operation
- FSM states:
  - `IDLE`: `imem_rd`=0, `busy`=0.
    - `fetch_req` → `REQ`.
  - `REQ`: `imem_rd`=1, `busy`=1.
    - `imem_valid` → capture.
  - Capture occurs on the `REQ` cycle where `imem_valid`=1:
    - IR ← `imem_rdata`; `pc_instr` ← PC; PC ← PC+4; `instr_valid` ← 1; next state `IDLE`.
- `fetch_req` in `REQ` is ignored; it is not queued.
- `instr_valid` clears on the cycle `IDLE` accepts `fetch_req`. The IR holds its value until the next capture.
- `pc_load` in `IDLE`: PC ← `pc_next`. With `fetch_req` in the same cycle, the PC is updated first, so the fetch uses `pc_next`.
- `pc_load` in `REQ`: `pc_next` is latched as pending; `imem_addr` is unchanged. At capture, PC ← pending value instead of PC+4, and the pending value clears. A second `pc_load` in `REQ` overwrites the pending value.
- `pc_load` with `pc_next[1:0]`≠0: ignored; `misalign` ← 1. `misalign` clears only on reset.
- PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Immediate selection by `op_code`:
  - I (0010011, 0000011, 1100111, 1110011): `instr[31:20]`.
  - S (0100011): {`instr[31:25]`, `instr[11:7]`}.
  - SB (1100011): {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
  - U (0110111): {`instr[31:12]`, 12'b0}.
  - UJ (1101111): {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
  - R (0110011): 0.
  - All formats sign-extend from `instr[31]` to 64 bits.
  - Any other opcode: `imm`=0, `illegal`=1.
- Reset values:
  - PC = `PC_RESET`; `pc_instr`=0; IR=0; pending load cleared; state `IDLE`.
  - `instr_valid`=0, `busy`=0, `imem_rd`=0, `misalign`=0.
  - `illegal`=1, because IR=0 has opcode 0.
- `RST` asserted mid-fetch aborts the fetch. `imem_rd` drops asynchronously, and a late `imem_valid` is ignored.

## Timing
- `fetch_req` at edge N → `imem_rd`=1 from cycle N+1.
- `imem_valid` at edge M → `instr`, `imm`, `instr_valid` and PC+4 visible after edge M.
- Minimum latency is 2 cycles, with `imem_valid` in the first `REQ` cycle.
- Back-to-back throughput: one instruction per 2+L cycles, where L is the memory wait cycles.
- Field slices, `imm` and `illegal` are combinational from the IR; there is no extra cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL);
  - the `instr_fmt_t` enum {FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD};
  - the fetch FSM state enum.
- Sub-module `imm_gen` is combinational: `instr` in → `imm`, `fmt`, `illegal` out. It is reused by later datapath blocks.

## Test plan
- Reset with `PC_RESET`=0x100, then `fetch_req`, `imem_valid` next cycle with 0x00A00093 → `instr`=0x00A00093, `imm`=10, `rd`=1, `pc_instr`=0x100, `pc`=0x104, `instr_valid`=1 two cycles after the request.
- `imem_valid` delayed 3 cycles → `imem_rd` and `busy` high for 4 cycles; a `fetch_req` pulsed mid-wait is ignored; exactly one capture.
- Fetch 0xFE000EE3 (beq, offset −4) → `imm`=0xFFFF_FFFF_FFFF_FFFC.
- Fetch 0x8000006F (jal) → `imm`=0xFFFF_FFFF_FFF0_0000.
- `pc_load`=0x200 during `REQ` → `imem_addr` unchanged until capture, then `pc`=0x200.
- `pc_load`=0x300 together with `fetch_req` in `IDLE` → `imem_addr`=0x300.
- `pc_load`=0x202 → `pc` unchanged, `misalign`=1.
- Fetch 0x0000007F → `illegal`=1.
- `RST` asserted while in `REQ` → `imem_rd`=0 immediately, `pc`=`PC_RESET`.
